// File: rtl/fpga_lut_cfg_loader.sv
// Serial configuration loader for the 4-LUT array: sync-word hunt, 16-bit word
// assembly with one-hot write strobes, and a trailing XOR checksum check.
module fpga_lut_cfg_loader #(
  parameter int unsigned NUM_LUTS  = 8,
  parameter logic [15:0] SYNC_WORD = 16'hA5C3
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                cfg_valid_i,
  input  logic                cfg_bit_i,
  output logic                cfg_ready_o,
  input  logic                cfg_restart_i,
  output logic [15:0]         lut_data_o,
  output logic [NUM_LUTS-1:0] lut_we_o,
  output logic                busy_o,
  output logic                cfg_done_o,
  output logic                cfg_error_o
);

  localparam int unsigned IdxW = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_LUTS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHunt,
    StLoad,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e              state_q, state_d;
  logic                init_q;
  logic [15:0]         shift_q, shift_d;
  logic [4:0]          hunt_cnt_q, hunt_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [15:0]         acc_q, acc_d;
  logic [15:0]         data_q, data_d;
  logic [NUM_LUTS-1:0] we_q, we_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic [15:0]         shift_next;

  assign accept     = cfg_valid_i && ready_q;
  assign shift_next = {shift_q[14:0], cfg_bit_i};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    hunt_cnt_d = hunt_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    data_d     = data_q;
    we_d       = '0;
    done_d     = done_q;
    err_d      = err_q;

    if (cfg_restart_i && (state_q != StIdle)) begin
      state_d    = StHunt;
      shift_d    = '0;
      hunt_cnt_d = '0;
      bit_cnt_d  = '0;
      idx_d      = '0;
      acc_d      = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Hold one cycle after reset release before hunting.
          if (init_q) begin
            state_d    = StHunt;
            shift_d    = '0;
            hunt_cnt_d = '0;
          end
        end
        StHunt: begin
          if (accept) begin
            shift_d = shift_next;
            if (hunt_cnt_q != 5'd16) hunt_cnt_d = hunt_cnt_q + 5'd1;
            // Compare only once the window holds 16 genuinely received bits.
            if ((hunt_cnt_q >= 5'd15) && (shift_next == SYNC_WORD)) begin
              state_d   = StLoad;
              bit_cnt_d = '0;
              idx_d     = '0;
              acc_d     = '0;
            end
          end
        end
        StLoad: begin
          if (accept) begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              data_d      = shift_next;
              we_d[idx_q] = 1'b1;
              acc_d       = acc_q ^ shift_next;
              idx_d       = idx_q + IdxW'(1);
              if (idx_q == LastIdx) begin
                state_d = StCheck;
                idx_d   = '0;
              end
            end
          end
        end
        StCheck: begin
          if (accept) begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              if (shift_next == acc_q) begin
                state_d = StDone;
                done_d  = 1'b1;
              end else begin
                state_d = StError;
                err_d   = 1'b1;
              end
            end
          end
        end
        StDone, StError: begin
        end
        default: state_d = StIdle;
      endcase
    end

    ready_d = (state_d == StHunt) || (state_d == StLoad) || (state_d == StCheck);
    busy_d  = (state_d == StLoad) || (state_d == StCheck);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      init_q     <= 1'b0;
      shift_q    <= '0;
      hunt_cnt_q <= '0;
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      we_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b1;
      shift_q    <= shift_d;
      hunt_cnt_q <= hunt_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
      we_q       <= we_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign lut_data_o  = data_q;
  assign lut_we_o    = we_q;
  assign busy_o      = busy_q;
  assign cfg_done_o  = done_q;
  assign cfg_error_o = err_q;

endmodule

// File: tb/tb_fpga_lut_cfg_loader.sv
// Directed bench for fpga_lut_cfg_loader: reset, frames, bad checksum, hunt,
// stalls, restart abort and mid-load reset, plus a SYNC_WORD=0001 instance.
module tb_fpga_lut_cfg_loader;

  logic        clk;
  logic        reset_n;
  logic        valid, bitv, restart;
  logic        ready, busy, done, err;
  logic [15:0] data;
  logic [1:0]  we;

  logic        v1, b1, restart1;
  logic        rdy1, busy1, done1, err1;
  logic [15:0] data1;
  logic [0:0]  we1;

  int nchecks = 0;
  int nerr    = 0;
  int nstrobe = 0;
  int base;

  fpga_lut_cfg_loader #(.NUM_LUTS(2), .SYNC_WORD(16'hA5C3)) u_dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .cfg_valid_i  (valid),
    .cfg_bit_i    (bitv),
    .cfg_ready_o  (ready),
    .cfg_restart_i(restart),
    .lut_data_o   (data),
    .lut_we_o     (we),
    .busy_o       (busy),
    .cfg_done_o   (done),
    .cfg_error_o  (err)
  );

  fpga_lut_cfg_loader #(.NUM_LUTS(1), .SYNC_WORD(16'h0001)) u_dut1 (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .cfg_valid_i  (v1),
    .cfg_bit_i    (b1),
    .cfg_ready_o  (rdy1),
    .cfg_restart_i(restart1),
    .lut_data_o   (data1),
    .lut_we_o     (we1),
    .busy_o       (busy1),
    .cfg_done_o   (done1),
    .cfg_error_o  (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we != 2'b00) nstrobe <= nstrobe + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the last bit's edge.
  task automatic send_bits(input logic [15:0] w, input int n, input int stall_pct);
    for (int i = 15; i > 15 - n; i--) begin
      for (int s = 0; s < 3 && stall_pct > 0 && $urandom_range(99) < stall_pct; s++) begin
        valid = 1'b0;
        @(negedge clk);
      end
      valid = 1'b1;
      bitv  = w[i];
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic good_frame(input string tag, input int stall_pct);
    base = nstrobe;
    send_bits(16'hA5C3, 16, stall_pct);
    check({tag, "_sync_busy"}, 32'(busy), 32'd1);
    send_bits(16'h8000, 16, stall_pct);
    check({tag, "_we0"}, 32'({we, data}), 32'({2'b01, 16'h8000}));
    send_bits(16'h00FF, 16, stall_pct);
    check({tag, "_we1"}, 32'({we, data}), 32'({2'b10, 16'h00FF}));
    send_bits(16'h80FF, 16, stall_pct);
    check({tag, "_done"}, 32'({done, err, ready, busy}), 32'b1000);
    check({tag, "_nstrobe"}, 32'(nstrobe - base), 32'd2);
    check({tag, "_data_hold"}, 32'(data), 32'h00FF);
  endtask

  initial begin
    reset_n  = 1'b0;
    valid    = 1'b0;
    bitv     = 1'b0;
    restart  = 1'b0;
    v1       = 1'b0;
    b1       = 1'b0;
    restart1 = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_outs", 32'({ready, data, we, busy, done, err}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_edge1_ready", 32'(ready), 32'd0);
    @(negedge clk);
    check("rel_edge2_ready", 32'({ready, busy}), 32'b10);

    // SYNC_WORD=0001: a lone '1' must not sync; a full 0001 afterwards must.
    v1 = 1'b1;
    b1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    repeat (2) @(negedge clk);
    check("s1_lone_bit", 32'(busy1), 32'd0);
    for (int i = 15; i >= 0; i--) begin
      v1 = 1'b1;
      b1 = (i == 0);
      @(negedge clk);
    end
    v1 = 1'b0;
    check("s1_sync", 32'(busy1), 32'd1);

    good_frame("basic", 0);

    pulse_restart();
    check("restart1", 32'({done, ready}), 32'b01);
    base = nstrobe;
    send_bits(16'hA5C3, 16, 0);
    send_bits(16'h8000, 16, 0);
    check("bad_we0", 32'({we, data}), 32'({2'b01, 16'h8000}));
    send_bits(16'h00FF, 16, 0);
    check("bad_we1", 32'({we, data}), 32'({2'b10, 16'h00FF}));
    send_bits(16'h80FE, 16, 0);
    check("bad_err", 32'({done, err, ready, busy}), 32'b0100);
    check("bad_nstrobe", 32'(nstrobe - base), 32'd2);
    pulse_restart();
    check("bad_clear", 32'({err, done, ready}), 32'b001);

    base = nstrobe;
    send_bits(16'b1011001_000000000, 7, 0);
    check("hunt_junk", 32'(busy), 32'd0);
    send_bits(16'hA5C3, 16, 0);
    check("hunt_sync", 32'(busy), 32'd1);
    send_bits(16'h1234, 16, 0);
    check("hunt_we0", 32'({we, data}), 32'({2'b01, 16'h1234}));
    send_bits(16'hABCD, 16, 0);
    check("hunt_we1", 32'({we, data}), 32'({2'b10, 16'hABCD}));
    send_bits(16'hB9F9, 16, 0);
    check("hunt_done", 32'({done, err}), 32'b10);
    check("hunt_nstrobe", 32'(nstrobe - base), 32'd2);

    pulse_restart();
    good_frame("stall", 50);

    pulse_restart();
    base = nstrobe;
    send_bits(16'hA5C3, 16, 0);
    send_bits(16'hFFFF, 5, 0);
    restart = 1'b1;
    valid   = 1'b1;
    bitv    = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    valid   = 1'b0;
    check("abort_state", 32'({we, busy, ready, done}), 32'b00010);
    check("abort_nstrobe", 32'(nstrobe - base), 32'd0);
    good_frame("abort_fresh", 0);

    pulse_restart();
    send_bits(16'hA5C3, 16, 0);
    send_bits(16'hFFFF, 15, 0);
    base    = nstrobe;
    reset_n = 1'b0;
    valid   = 1'b1;
    bitv    = 1'b1;
    @(negedge clk);
    check("midrst_outs", 32'({ready, data, we, busy, done, err}), 32'd0);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_nstrobe", 32'(nstrobe - base), 32'd0);
    check("midrst_recover", 32'({ready, busy}), 32'b10);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
